bcd_ex3_codec: RTL and testbench
================================

// Module: bcd_ex3_codec
// PURPOSE
//  Multi-digit, bidirectional BCD <-> excess-3 converter with valid/ready handshakes on both sides.
//  Accepts a packed word of DIGITS nibbles and converts one digit per clock, least-significant digit first.
//  Flags any digit that is illegal for the selected mode.
//  Sits between digit sources (keypad/counter datapaths) and ex3-based arithmetic/display logic.
//  Replaces the single-digit combinational encoder.
// PARAMETERS
//  DIGITS   4   number of 4-bit digits per word (>=1); digit i = data[4*i+3:4*i]
// PORTS
//  clk           in   1          single clock; all logic on posedge
//  rst           in   1          synchronous, active-high reset
//  in_valid      in   1          input word present
//  in_ready      out  1          block can accept a word
//  in_data       in   4*DIGITS   packed input digits
//  in_mode       in   1          0 = BCD->ex3, 1 = ex3->BCD; sampled at accept
//  out_valid     out  1          result word present
//  out_ready     in   1          downstream accepts result
//  out_data      out  4*DIGITS   packed converted digits
//  out_err       out  1          OR of out_err_mask
//  out_err_mask  out  DIGITS     bit i set = digit i illegal
// BEHAVIOUR
//  Reset values
//  - rst high at a posedge clears:
//    - state to IDLE, out_valid=0, out_data=0, out_err_mask=0, digit counter=0.
//  - in_ready is 1 in the first cycle after reset.
//  - Reset overrides everything, including mid-CONV and DONE; a word in flight is discarded.
//  FSM: IDLE -> CONV -> DONE -> IDLE
//  - IDLE:
//    - in_ready=1.
//    - On in_valid at posedge (cycle T): latch in_data and in_mode, clear out_err_mask, cnt=0, go to CONV.
//  - CONV:
//    - in_ready=0, out_valid=0.
//    - Cycle T+1+i converts digit cnt=i and writes result nibble i and mask bit i.
//    - After i=DIGITS-1, go to DONE.
//  - DONE:
//    - out_valid=1; out_data and out_err_mask held stable while out_ready=0.
//    - out_valid & out_ready at a posedge -> IDLE and out_valid=0 the next cycle.
//    - in_ready stays 0 in DONE: no same-cycle accept.
//  Timing
//  - out_valid first high in cycle T+DIGITS+1.
//  - Minimum spacing between accepts is DIGITS+2 cycles.
//  Digit rules
//  - Mode 0 (BCD->ex3):
//    - legal 0..9 -> d+3, 4-bit.
//    - 10..15 illegal.
//  - Mode 1 (ex3->BCD):
//    - legal 3..12 -> d-3, 4-bit.
//    - 0..2 and 13..15 illegal.
//  - Illegal digit: result nibble = 4'hF, mask bit set.
//  - Arithmetic is 4-bit modulo; no carries between digits.
//  Other rules
//  - in_data and in_mode changes outside the accept cycle have no effect.
//  - Digit counter width is max(1,$clog2(DIGITS)).
//  - DIGITS=1 must work: CONV lasts one cycle.
//  - out_err is combinational |out_err_mask and is valid only while out_valid=1.
// STRUCTURE
//  - Shared include bcd_ex3_defs.vh:
//    - state encodings ST_IDLE/ST_CONV/ST_DONE
//    - EX3_OFFSET=4'd3, DIGIT_INVALID=4'hF, BCD_MAX=4'd9, EX3_MIN=4'd3, EX3_MAX=4'd12.
//  - Sub-module ex3_digit: combinational single-nibble converter.
//    - Ports: mode, d_in[3:0], d_out[3:0], illegal.
//    - Instantiated once, fed by the digit selected by cnt.
//  - Top level holds the FSM, counter, and the input/result/mask registers.
// TESTING (DIGITS=4 unless noted)
//  1. Mode 0, in_data=16'h1234, out_ready=1:
//     out_valid at T+5, out_data=16'h4567, mask=4'b0000, in_ready back to 1 at T+6.
//  2. Mode 1, in_data=16'h4567 -> out_data=16'h1234, out_err=0.
//     Mode 1, in_data=16'h0C3D -> out_data=16'hF90F, mask=4'b1001, out_err=1.
//  3. Mode 0, in_data=16'h9A05 -> out_data=16'hCF38, mask=4'b0100.
//  4. Backpressure:
//     - Hold out_ready=0 for 10 cycles; out_data and out_err_mask stay stable, in_ready=0.
//     - Keep in_valid=1 with new data throughout.
//     - Raise out_ready: result accepted, next word accepted only from IDLE.
//  5. Reset mid-operation:
//     - Assert rst at T+2.
//     - Next cycle: out_valid=0, out_data=0, in_ready=1.
//     - A following word 16'h0000 in mode 0 yields 16'h3333.
//  6. Exhaustive sweep:
//     - DIGITS=1 and DIGITS=4, both modes, every nibble 0..15 in every position.
//     - Check against reference model; check latency and error mask on each word.

Source files
------------

// File: rtl/bcd_ex3_codec_pkg.sv
// Shared definitions for the BCD <-> excess-3 codec.
//   state_e        : controller states (idle / converting / result held)
//   EX3_OFFSET     : distance between a BCD digit and its excess-3 code
//   DIGIT_INVALID  : nibble substituted for any illegal input digit
//   BCD_MAX        : largest legal BCD digit
//   EX3_MIN/MAX    : legal excess-3 code range
//   digit_illegal  : legality check for one nibble in the selected mode
package bcd_ex3_codec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] EX3_OFFSET    = 4'd3;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;
    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] EX3_MIN       = 4'd3;
    localparam logic [3:0] EX3_MAX       = 4'd12;

    // mode 0: input is BCD (0..9 legal); mode 1: input is excess-3 (3..12 legal)
    function automatic logic digit_illegal(input logic mode, input logic [3:0] d);
        logic bad;
        if (mode) begin
            bad = (d < EX3_MIN) || (d > EX3_MAX);
        end else begin
            bad = (d > BCD_MAX);
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_ex3_codec_ex3_digit.sv
// Single-nibble combinational BCD <-> excess-3 converter.
//   mode    in  : 0 = BCD->ex3, 1 = ex3->BCD
//   d_in    in  : input digit
//   d_out   out : converted digit, or all-ones when the input is illegal
//   illegal out : input digit outside the legal range for mode
module ex3_digit
    import bcd_ex3_codec_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] d_in,
    output logic [3:0] d_out,
    output logic       illegal
);

    // Legality check and 4-bit modulo offset; illegal digits map to the invalid marker
    always_comb begin
        illegal = digit_illegal(mode, d_in);
        if (illegal) begin
            d_out = DIGIT_INVALID;
        end else if (mode) begin
            d_out = d_in - EX3_OFFSET;
        end else begin
            d_out = d_in + EX3_OFFSET;
        end
    end

endmodule

// File: rtl/bcd_ex3_codec.sv
// Multi-digit BCD <-> excess-3 converter, one digit per clock, LSD first.
//   clk, rst       : clock and synchronous active-high reset
//   in_valid/ready : input handshake; word and mode captured on accept
//   in_data        : DIGITS packed nibbles, digit i = in_data[4*i+3:4*i]
//   in_mode        : 0 = BCD->ex3, 1 = ex3->BCD
//   out_valid/ready: result handshake; result held stable until taken
//   out_data       : converted digits (illegal digits read as 4'hF)
//   out_err        : any digit illegal (meaningful only while out_valid)
//   out_err_mask   : per-digit illegal flags
// A word accepted at cycle T produces out_valid at T+DIGITS+1. The block
// does not accept a new word while a result is held, so accepts are spaced
// at least DIGITS+2 cycles apart.
module bcd_ex3_codec
    import bcd_ex3_codec_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W  = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        src_q, src_d;
    logic [W-1:0]        res_q, res_d;
    logic                mode_q, mode_d;
    logic [DIGITS-1:0]   mask_q, mask_d;

    logic [W-1:0]        src_shift_s;
    logic [3:0]          cur_digit_s;
    logic [3:0]          conv_digit_s;
    logic                conv_illegal_s;

    // Select the digit addressed by the counter (shift by 4*cnt)
    always_comb begin
        src_shift_s = src_q >> {cnt_q, 2'b00};
        cur_digit_s = src_shift_s[3:0];
    end

    ex3_digit u_digit (
        .mode    (mode_q),
        .d_in    (cur_digit_s),
        .d_out   (conv_digit_s),
        .illegal (conv_illegal_s)
    );

    // Controller next-state, counter and datapath register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    mode_d  = in_mode;
                    mask_d  = {DIGITS{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                // Only the nibble and mask bit addressed by cnt change this cycle
                for (int i = 0; i < DIGITS; i++) begin
                    res_d[4*i +: 4] = (cnt_q == CW'(i)) ? conv_digit_s : res_q[4*i +: 4];
                    mask_d[i]       = (cnt_q == CW'(i)) ? conv_illegal_s : mask_q[i];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_CONV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            src_q   <= {W{1'b0}};
            res_q   <= {W{1'b0}};
            mode_q  <= 1'b0;
            mask_q  <= {DIGITS{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
        end
    end

    // Handshake flags decode directly from the state register
    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        out_valid    = (state_q == ST_DONE);
        out_data     = res_q;
        out_err_mask = mask_q;
        out_err      = |mask_q;
    end

endmodule

// File: tb/tb_bcd_ex3_codec.sv
// Directed self-checking bench for bcd_ex3_codec (DIGITS=4 and DIGITS=1 instances).
module tb_bcd_ex3_codec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_valid1 = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready1 = 1'b1;

    logic        in_ready, out_valid, out_err;
    logic [15:0] out_data;
    logic [3:0]  out_err_mask;
    logic        in_ready1, out_valid1, out_err1;
    logic [3:0]  out_data1;
    logic [0:0]  out_err_mask1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_ex3_codec #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .out_err_mask(out_err_mask)
    );

    bcd_ex3_codec #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data[3:0]), .in_mode(in_mode), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .out_err(out_err1),
        .out_err_mask(out_err_mask1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference digit rule written from the conversion table
    function automatic logic [4:0] ref_digit(input logic mode, input logic [3:0] d);
        if (mode == 1'b0) begin
            if (d <= 4'd9) return {1'b0, d + 4'd3};
            else           return {1'b1, 4'hF};
        end else begin
            if (d >= 4'd3 && d <= 4'd12) return {1'b0, d - 4'd3};
            else                         return {1'b1, 4'hF};
        end
    endfunction

    // One full transaction starting from IDLE; sel=1 uses the 1-digit instance
    task automatic run_word(input bit sel, input logic mode, input logic [15:0] data,
                            input logic [15:0] exp_data, input logic [3:0] exp_mask,
                            input string tag);
        int n;
        int nd;
        logic ov;
        nd = sel ? 1 : 4;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, sel ? in_ready1 : in_ready, 1'b1);
        in_data = data;
        in_mode = mode;
        out_ready = 1'b1;
        if (sel) in_valid1 = 1'b1;
        else     in_valid  = 1'b1;
        n = 0;
        ov = 1'b0;
        while (!ov && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_valid  = 1'b0;
                in_valid1 = 1'b0;
                check({tag, "_in_ready_conv"}, sel ? in_ready1 : in_ready, 1'b0);
            end
            ov = sel ? out_valid1 : out_valid;
        end
        check({tag, "_latency"}, n, nd + 1);
        check({tag, "_data"}, sel ? {28'h0, out_data1} : {16'h0, out_data}, {16'h0, exp_data});
        check({tag, "_mask"}, sel ? {31'h0, out_err_mask1} : {28'h0, out_err_mask}, {28'h0, exp_mask});
        check({tag, "_err"}, sel ? out_err1 : out_err, |exp_mask);
        @(negedge clk);
        check({tag, "_valid_drop"}, sel ? out_valid1 : out_valid, 1'b0);
        check({tag, "_in_ready_back"}, sel ? in_ready1 : in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] e;
        logic [3:0]  mk;
        logic [4:0]  r;
        int n;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_mask", out_err_mask, 4'b0000);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_in_ready1", in_ready1, 1'b1);

        // Directed vectors
        run_word(1'b0, 1'b0, 16'h1234, 16'h4567, 4'b0000, "m0_1234");
        run_word(1'b0, 1'b1, 16'h4567, 16'h1234, 4'b0000, "m1_4567");
        run_word(1'b0, 1'b1, 16'h0C3D, 16'hF90F, 4'b1001, "m1_0C3D");
        run_word(1'b0, 1'b0, 16'h9A05, 16'hCF38, 4'b0100, "m0_9A05");

        // Backpressure with in_valid held and data churning
        @(negedge clk);
        out_ready = 1'b0;
        in_mode = 1'b0;
        in_data = 16'h1234;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            in_data = 16'($urandom);
            in_mode = 1'($urandom);
        end while (!out_valid && n < 20);
        check("bp_latency", n, 5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_data", out_data, 16'h4567);
            check("bp_mask", out_err_mask, 4'b0000);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_valid", out_valid, 1'b1);
            in_data = 16'($urandom);
            in_mode = 1'($urandom);
        end
        out_ready = 1'b1;
        in_data = 16'h4567;
        in_mode = 1'b0;
        @(negedge clk);
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accepted", in_ready, 1'b0);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_latency", n, 5);
        check("bp_next_data", out_data, 16'h789A);
        @(negedge clk);

        // Reset in the middle of a conversion
        @(negedge clk);
        in_data = 16'h1234;
        in_mode = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 16'h0000);
        check("mid_rst_mask", out_err_mask, 4'b0000);
        check("mid_rst_in_ready", in_ready, 1'b1);
        run_word(1'b0, 1'b0, 16'h0000, 16'h3333, 4'b0000, "after_rst");

        // Sweep: every nibble value in every position, both modes
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 16; v++) begin
                for (int k = 0; k < 4; k++) begin
                    d[4*k +: 4] = 4'(v + k);
                    r = ref_digit(1'(m), d[4*k +: 4]);
                    e[4*k +: 4] = r[3:0];
                    mk[k] = r[4];
                end
                run_word(1'b0, 1'(m), d, e, mk, "sweep4");
                r = ref_digit(1'(m), 4'(v));
                run_word(1'b1, 1'(m), {12'h000, 4'(v)}, {12'h000, r[3:0]}, {3'b000, r[4]}, "sweep1");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
